// File: rtl/multi_unit_arbiter_pkg.sv
// Shared ALU definitions for the MultiUnit arbiter: FSM states, requester
// indices and the default operand width.
package alu_pkg;

  localparam int DW_DEF = 32;

  localparam logic REQ_MULTI = 1'b0;
  localparam logic REQ_DIV   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/multi_unit_arbiter_if.sv
// Request/grant/return bundle between the Multi/Div engines, the arbiter and
// the shared MultiUnit. The arbiter uses the slave side, everything else the master side.
interface multi_unit_arbiter_if
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic [DW-1:0] multi_data1_in;
  logic [DW-1:0] multi_data2_in;
  logic          multi_trig;
  logic          multi_vld;
  logic [DW-1:0] div_data1_in;
  logic [DW-1:0] div_data2_in;
  logic          div_trig;
  logic          div_vld;
  logic [DW-1:0] result_out;
  logic [DW-1:0] unit_data1;
  logic [DW-1:0] unit_data2;
  logic          unit_trig;
  logic [DW-1:0] unit_result;
  logic          unit_vld;
  logic          unit_sel;
  logic          busy;
  logic [1:0]    ovf;

  modport slave (
    input  multi_data1_in, multi_data2_in, multi_trig,
    input  div_data1_in, div_data2_in, div_trig,
    input  unit_result, unit_vld,
    output multi_vld, div_vld, result_out,
    output unit_data1, unit_data2, unit_trig, unit_sel,
    output busy, ovf
  );

  modport master (
    output multi_data1_in, multi_data2_in, multi_trig,
    output div_data1_in, div_data2_in, div_trig,
    output unit_result, unit_vld,
    input  multi_vld, div_vld, result_out,
    input  unit_data1, unit_data2, unit_trig, unit_sel,
    input  busy, ovf
  );
endinterface

// File: rtl/multi_unit_arbiter_req_buf.sv
// One-deep request slot per requester: pending bit, operand buffer and a
// sticky overrun flag for triggers that arrive while the slot is still full.
module arb_req_buf
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          trig,
  input  logic          clr,
  input  logic [DW-1:0] data1_in,
  input  logic [DW-1:0] data2_in,
  output logic          pending,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  output logic          ovf
);

  // A grant in the same cycle frees the slot, so a coincident trigger is kept.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pending <= 1'b0;
      data1   <= {DW{1'b0}};
      data2   <= {DW{1'b0}};
      ovf     <= 1'b0;
    end else if (trig && pending && !clr) begin
      ovf <= 1'b1;
    end else if (trig) begin
      pending <= 1'b1;
      data1   <= data1_in;
      data2   <= data2_in;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_unit_arbiter.sv
// Sequencing arbiter sharing the single MultiUnit between Multi and Div.
// Optional MU_ARB_RR_EN: round-robin on ties instead of fixed Multi priority.
module multi_unit_arbiter
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  multi_unit_arbiter_if.slave bus
);

  state_t        state_r;
  logic          m_pend_s;
  logic          d_pend_s;
  logic          m_ovf_s;
  logic          d_ovf_s;
  logic [DW-1:0] m_d1_s;
  logic [DW-1:0] m_d2_s;
  logic [DW-1:0] d_d1_s;
  logic [DW-1:0] d_d2_s;
  logic          grant_s;
  logic          winner_s;
  logic          m_clr_s;
  logic          d_clr_s;
`ifdef MU_ARB_RR_EN
  logic          last_grant_r;
`endif

  assign grant_s = (state_r == IDLE) && (m_pend_s || d_pend_s);
  assign m_clr_s = grant_s && (winner_s == REQ_MULTI);
  assign d_clr_s = grant_s && (winner_s == REQ_DIV);
  assign bus.ovf = {d_ovf_s, m_ovf_s};

  arb_req_buf #(.DW(DW)) u_multi_buf (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .trig     (bus.multi_trig),
    .clr      (m_clr_s),
    .data1_in (bus.multi_data1_in),
    .data2_in (bus.multi_data2_in),
    .pending  (m_pend_s),
    .data1    (m_d1_s),
    .data2    (m_d2_s),
    .ovf      (m_ovf_s)
  );

  arb_req_buf #(.DW(DW)) u_div_buf (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .trig     (bus.div_trig),
    .clr      (d_clr_s),
    .data1_in (bus.div_data1_in),
    .data2_in (bus.div_data2_in),
    .pending  (d_pend_s),
    .data1    (d_d1_s),
    .data2    (d_d2_s),
    .ovf      (d_ovf_s)
  );

  // Winner selection: a lone requester always wins; ties go by the configured policy.
  always_comb begin
    winner_s = REQ_MULTI;
    if (m_pend_s && d_pend_s) begin
`ifdef MU_ARB_RR_EN
      winner_s = ~last_grant_r;
`else
      winner_s = REQ_MULTI;
`endif
    end else if (d_pend_s) begin
      winner_s = REQ_DIV;
    end else begin
      winner_s = REQ_MULTI;
    end
  end

`ifdef MU_ARB_RR_EN
  // Last-grant pointer; starts at Div so the first tie after reset goes to Multi.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_grant_r <= REQ_DIV;
    end else if (grant_s) begin
      last_grant_r <= winner_s;
    end
  end
`endif

  // Issue/wait/return sequencer; operands stay on the unit bus until the next grant.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r        <= IDLE;
      bus.unit_data1 <= {DW{1'b0}};
      bus.unit_data2 <= {DW{1'b0}};
      bus.unit_sel   <= 1'b0;
      bus.unit_trig  <= 1'b0;
      bus.result_out <= {DW{1'b0}};
      bus.multi_vld  <= 1'b0;
      bus.div_vld    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bus.multi_vld <= 1'b0;
          bus.div_vld   <= 1'b0;
          if (grant_s) begin
            state_r        <= ISSUE;
            bus.unit_sel   <= winner_s;
            bus.unit_data1 <= (winner_s == REQ_DIV) ? d_d1_s : m_d1_s;
            bus.unit_data2 <= (winner_s == REQ_DIV) ? d_d2_s : m_d2_s;
            bus.unit_trig  <= 1'b1;
            bus.busy       <= 1'b1;
          end
        end
        ISSUE: begin
          bus.unit_trig <= 1'b0;
          state_r       <= WAIT;
        end
        WAIT: begin
          if (bus.unit_vld) begin
            bus.result_out <= bus.unit_result;
            bus.multi_vld  <= (bus.unit_sel == REQ_MULTI);
            bus.div_vld    <= (bus.unit_sel == REQ_DIV);
            state_r        <= DONE;
          end
        end
        DONE: begin
          bus.multi_vld <= 1'b0;
          bus.div_vld   <= 1'b0;
          bus.busy      <= 1'b0;
          state_r       <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_unit_arbiter.sv
// Scoreboard bench for multi_unit_arbiter: directed requests, a fixed-latency
// MultiUnit model, and a monitor checking every returned result against a queue.
module tb_multi_unit_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic        sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] res;
  } op_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        model_vld = 1'b0;
  logic        stray_vld = 1'b0;
  logic [31:0] model_res = 32'h0;
  logic [31:0] stray_res = 32'h0;
  logic        model_busy = 1'b0;
  logic        abort_op = 1'b0;
  int          cyc = 0;
  int          issue_cyc = 0;
  int          vld_cyc = 0;
  int          t0 = 0;
  int          n_vec = 0;
  int          n_err = 0;
  op_t         issue_q[$];
  op_t         ret_q[$];

  multi_unit_arbiter_if #(.DW(32)) bus ();

  multi_unit_arbiter #(.DW(32)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  assign bus.unit_vld    = model_vld | stray_vld;
  assign bus.unit_result = stray_vld ? stray_res : model_res;

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_op(input logic sel, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] res, input logic ret);
    op_t e;
    e = '{sel: sel, d1: d1, d2: d2, res: res};
    issue_q.push_back(e);
    if (ret) ret_q.push_back(e);
  endtask

  // Called at a negedge; holds the triggers for exactly one cycle.
  task automatic drive(input logic m, input logic d, input logic [31:0] md1, input logic [31:0] md2,
                       input logic [31:0] dd1, input logic [31:0] dd2);
    bus.multi_trig     = m;
    bus.div_trig       = d;
    bus.multi_data1_in = md1;
    bus.multi_data2_in = md2;
    bus.div_data1_in   = dd1;
    bus.div_data2_in   = dd2;
    @(negedge sys_clk);
    bus.multi_trig = 1'b0;
    bus.div_trig   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((issue_q.size() != 0 || ret_q.size() != 0 || model_busy || bus.busy) && n < 80) begin
      @(negedge sys_clk);
      n++;
    end
    check("idle_within_budget", 32'(n < 80), 32'd1);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_multi_vld"}, {31'd0, bus.multi_vld}, 32'd0);
    check({tag, "_div_vld"}, {31'd0, bus.div_vld}, 32'd0);
    check({tag, "_result_out"}, bus.result_out, 32'd0);
    check({tag, "_unit_data1"}, bus.unit_data1, 32'd0);
    check({tag, "_unit_data2"}, bus.unit_data2, 32'd0);
    check({tag, "_unit_trig"}, {31'd0, bus.unit_trig}, 32'd0);
    check({tag, "_unit_sel"}, {31'd0, bus.unit_sel}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_ovf"}, {30'd0, bus.ovf}, 32'd0);
  endtask

  // MultiUnit model: latency 4 from the unit_trig cycle to the unit_vld cycle.
  initial begin
    op_t e;
    forever begin
      @(negedge sys_clk);
      if (bus.unit_trig) begin
        issue_cyc = cyc;
        e = '0;
        check("issue_expected", 32'(issue_q.size() != 0), 32'd1);
        if (issue_q.size() != 0) begin
          e = issue_q.pop_front();
          check("issue_sel", {31'd0, bus.unit_sel}, {31'd0, e.sel});
          check("issue_data1", bus.unit_data1, e.d1);
          check("issue_data2", bus.unit_data2, e.d2);
        end
        model_busy = 1'b1;
        repeat (3) @(negedge sys_clk);
        if (!abort_op) begin
          check("hold_data1", bus.unit_data1, e.d1);
          check("hold_data2", bus.unit_data2, e.d2);
        end
        @(negedge sys_clk);
        model_vld = 1'b1;
        model_res = e.res;
        @(negedge sys_clk);
        model_vld  = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  // Return monitor: every owner vld pulse must match the next expected return.
  initial begin
    op_t r;
    forever begin
      @(negedge sys_clk);
      if (bus.multi_vld || bus.div_vld) begin
        vld_cyc = cyc;
        check("vld_exclusive", {31'd0, bus.multi_vld & bus.div_vld}, 32'd0);
        check("ret_expected", 32'(ret_q.size() != 0), 32'd1);
        if (ret_q.size() != 0) begin
          r = ret_q.pop_front();
          check("ret_owner", {31'd0, bus.div_vld}, {31'd0, r.sel});
          check("ret_result", bus.result_out, r.res);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.multi_trig     = 1'b0;
    bus.div_trig       = 1'b0;
    bus.multi_data1_in = 32'h0;
    bus.multi_data2_in = 32'h0;
    bus.div_data1_in   = 32'h0;
    bus.div_data2_in   = 32'h0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_zero("reset");

    // Single Multi request: 1.5 * 2.0 = 3.0
    expect_op(REQ_MULTI, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b1);
    t0 = cyc;
    drive(1'b1, 1'b0, 32'h3FC00000, 32'h40000000, 32'h0, 32'h0);
    wait_idle();
    check("t1_trig_latency", 32'(issue_cyc - t0), 32'd2);
    check("t1_vld_latency", 32'(vld_cyc - t0), 32'd7);
    check("t1_result_held", bus.result_out, 32'h40400000);
    check("t1_ovf", {30'd0, bus.ovf}, 32'd0);

    // Stray unit_vld while idle must be ignored
    stray_res = 32'h12345678;
    stray_vld = 1'b1;
    @(negedge sys_clk);
    stray_vld = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("stray_result_unchanged", bus.result_out, 32'h40400000);
    check("stray_busy", {31'd0, bus.busy}, 32'd0);

    // div_trig in the cycle its pending is granted: both ops served, no overrun
    expect_op(REQ_DIV, 32'h40400000, 32'h40800000, 32'h41400000, 1'b1);
    expect_op(REQ_DIV, 32'h3F800000, 32'h40A00000, 32'h40A00000, 1'b1);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h40400000, 32'h40800000);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h3F800000, 32'h40A00000);
    wait_idle();
    check("setwins_ovf", {30'd0, bus.ovf}, 32'd0);

    // Tie after reset, then a second tie formed by a new Multi request during service
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    expect_op(REQ_MULTI, 32'hBF800000, 32'h40000000, 32'hC0000000, 1'b1);
`ifdef MU_ARB_RR_EN
    expect_op(REQ_DIV, 32'h40000000, 32'h40000000, 32'h40800000, 1'b1);
    expect_op(REQ_MULTI, 32'h40400000, 32'h40400000, 32'h41100000, 1'b1);
`else
    expect_op(REQ_MULTI, 32'h40400000, 32'h40400000, 32'h41100000, 1'b1);
    expect_op(REQ_DIV, 32'h40000000, 32'h40000000, 32'h40800000, 1'b1);
`endif
    drive(1'b1, 1'b1, 32'hBF800000, 32'h40000000, 32'h40000000, 32'h40000000);
    repeat (2) @(negedge sys_clk);
    drive(1'b1, 1'b0, 32'h40400000, 32'h40400000, 32'h0, 32'h0);
    wait_idle();
    check("tie_ovf", {30'd0, bus.ovf}, 32'd0);

    // Second div_trig while Div is still pending behind a busy unit
    expect_op(REQ_MULTI, 32'h3F000000, 32'h40000000, 32'h3F800000, 1'b1);
    expect_op(REQ_DIV, 32'h40800000, 32'h40800000, 32'h41800000, 1'b1);
    drive(1'b1, 1'b0, 32'h3F000000, 32'h40000000, 32'h0, 32'h0);
    repeat (2) @(negedge sys_clk);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h40800000, 32'h40800000);
    @(negedge sys_clk);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h11111111, 32'h22222222);
    wait_idle();
    check("overrun_ovf", {30'd0, bus.ovf}, 32'd2);

    // Reset during WAIT: the late unit result must not produce a vld pulse
    expect_op(REQ_MULTI, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0);
    drive(1'b1, 1'b0, 32'h40000000, 32'h40000000, 32'h0, 32'h0);
    n = 0;
    while (issue_q.size() != 0 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    check("abort_issue_seen", 32'(n < 20), 32'd1);
    @(negedge sys_clk);
    abort_op = 1'b1;
    sys_rst  = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (8) @(negedge sys_clk);
    abort_op = 1'b0;
    check_zero("abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_unit_arbiter.md
# multi_unit_arbiter

Sequencing arbiter for the single shared 32-bit IEEE754 MultiUnit in the ALU. Accepts independent single-cycle operation triggers from the Multi and Div engines, buffers one request per requester, and issues them to MultiUnit one at a time. Routes each unit result back to its owner. Replaces the static select-line muxing of unit operands and trigger with a proper request/grant/return handshake.

## Interface
Parameters:
- DW, 32, operand/result width (IEEE754 single)

Ports:
- sys_clk  in  1  system clock, all state on rising edge
- sys_rst  in  1  synchronous, active-high reset
- multi_data1_in / multi_data2_in  in  DW  Multi operands, sampled with multi_trig
- multi_trig  in  1  Multi request pulse (one cycle)
- multi_vld  out  1  one-cycle pulse: result for Multi on result_out
- div_data1_in / div_data2_in  in  DW  Div operands, sampled with div_trig
- div_trig  in  1  Div request pulse (one cycle)
- div_vld  out  1  one-cycle pulse: result for Div on result_out
- result_out  out  DW  registered unit result, held until next return
- unit_data1 / unit_data2  out  DW  operands to MultiUnit, held stable ISSUE through WAIT
- unit_trig  out  1  one-cycle start pulse to MultiUnit
- unit_result  in  DW  MultiUnit result
- unit_vld  in  1  MultiUnit result valid pulse
- unit_sel  out  1  current owner: 0 = Multi, 1 = Div
- busy  out  1  high in ISSUE, WAIT, DONE
- ovf  out  2  sticky overrun flags, [0] Multi, [1] Div

## Operation
- Per requester: pending bit + operand buffer. trig sets pending and latches operands.
- trig while own pending already set: request dropped, buffer unchanged, ovf bit set (sticky until reset).
- trig in same cycle its pending is cleared by grant: set wins, new request captured.
- FSM states IDLE, ISSUE, WAIT, DONE:
  - IDLE: if any pending -> ISSUE. Load winner's buffer into unit_data1/2, set unit_sel, clear winner's pending.
  - ISSUE: unit_trig = 1 for exactly this cycle -> WAIT.
  - WAIT: on unit_vld, capture unit_result into result_out -> DONE.
  - DONE: assert multi_vld or div_vld per unit_sel -> IDLE.
- Arbitration on tie (both pending in IDLE): see Configuration. Single pending always wins.
- unit_vld outside WAIT: ignored, no state change.
- Reset values: all outputs 0; state IDLE; pending, buffers, ovf cleared; last-grant pointer = Div (1).
- Reset mid-operation: returns to IDLE immediately. In-flight unit result is ignored. No vld pulse is issued for aborted requests.

## Timing
- trig at cycle T -> pending at T+1 -> ISSUE (unit_trig high) at T+2 if unit idle.
- unit_vld at cycle U -> result_out valid and owner vld high at U+1.
- End-to-end latency with an idle unit is unit latency + 3 cycles.
- Back-to-back: after DONE, IDLE takes one cycle. The next unit_trig comes at the earliest 2 cycles after the vld pulse.
- Exactly one of multi_vld, div_vld is high per returned operation. The two are never high together.

## Configuration
- MU_ARB_RR_EN defined: round-robin on tie; the grant goes to the requester not granted last. The pointer updates on every grant.
- Not defined: fixed priority, Multi always wins a tie. The pointer logic is absent.

## Structure
- Shared package alu_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - requester index constants REQ_MULTI=0, REQ_DIV=1
  - DW default
- Sub-module arb_req_buf, instantiated twice: pending bit, operand buffer, ovf flag. The FSM and grant logic stay in the top.

## Test plan
- Single Multi request 0x3FC00000 × 0x40000000, model unit latency 4 -> unit_trig at T+2 with those operands, multi_vld at T+7, result_out=0x40400000, div_vld stays 0.
- multi_trig and div_trig in the same cycle, both pending, RR enabled, after reset -> Multi served first, then Div. Repeat the tie -> Div first. Without the macro: Multi first both times.
- Second div_trig while Div pending -> ovf=2'b10, only the first operands issued, one div_vld.
- unit_vld pulsed in IDLE -> no vld out, result_out unchanged, state IDLE.
- sys_rst asserted in WAIT, then unit_vld arrives -> no vld pulse, all outputs 0, pending cleared.
- div_trig in the same cycle Div's pending is granted -> second Div op issued after first completes, ovf stays 0.
